// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus writeback arbiter.
// Holds the default widths, the source index map and the queue entry layout.
package cdb_pkg;
  localparam int VREG_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int NUM_SRC_DEF = 3;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSB = 1;
  localparam int SRC_BRU = 2;

  typedef struct packed {
    logic [VREG_W_DEF-1:0] vregid;
    logic [DATA_W_DEF-1:0] val;
  } cdb_entry_t;
endpackage

// File: rtl/wb_src_queue.sv
// Small per-source writeback FIFO. The head is read combinationally so the
// arbiter can grant and register it in the same cycle.
module wb_src_queue
  import cdb_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = cdb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t entry_in,
  output entry_t head,
  output logic   empty,
  output logic   full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  // Flush wins over both push and pop; a full queue refuses even when popped.
  assign w_push = push & ~flush & ~full;
  assign w_pop  = pop & ~flush & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= entry_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rptr];
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single CDB writeback port between the
// functional units; one registered broadcast per cycle with a flush path.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter  int NUM_SRC = NUM_SRC_DEF,
  parameter  int VREG_W  = VREG_W_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int DEPTH   = 2,
  localparam int SW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*VREG_W-1:0] src_vregid,
  input  logic [NUM_SRC*DATA_W-1:0] src_val,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb_en,
  output logic [VREG_W-1:0]         cdb_vregid,
  output logic [DATA_W-1:0]         cdb_val,
  output logic [SW-1:0]             cdb_src
);
  typedef struct packed {
    logic [VREG_W-1:0] vregid;
    logic [DATA_W-1:0] val;
  } entry_t;

  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  entry_t             w_head [NUM_SRC];
  logic               w_grant;
  logic [SW-1:0]      w_grant_idx;

  logic [SW-1:0]      r_rr_ptr;
  logic               r_cdb_en;
  logic [VREG_W-1:0]  r_cdb_vregid;
  logic [DATA_W-1:0]  r_cdb_val;
  logic [SW-1:0]      r_cdb_src;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    entry_t w_in;
    assign w_in.vregid = src_vregid[gi*VREG_W +: VREG_W];
    assign w_in.val    = src_val[gi*DATA_W +: DATA_W];
    assign w_push[gi]  = src_valid[gi] & ~w_full[gi] & ~flush;
    assign w_pop[gi]   = w_grant & (w_grant_idx == SW'(gi)) & ~flush;

    wb_src_queue #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
    ) u_queue (
      .clk      (clk),
      .rst      (rst),
      .push     (w_push[gi]),
      .pop      (w_pop[gi]),
      .flush    (flush),
      .entry_in (w_in),
      .head     (w_head[gi]),
      .empty    (w_empty[gi]),
      .full     (w_full[gi])
    );
  end

  // Scan from the far end back to rr_ptr so the last hit is the first in rotation.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (!w_empty[(int'(r_rr_ptr) + k) % NUM_SRC]) begin
        w_grant     = 1'b1;
        w_grant_idx = SW'((int'(r_rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr     <= '0;
      r_cdb_en     <= 1'b0;
      r_cdb_vregid <= '0;
      r_cdb_val    <= '0;
      r_cdb_src    <= '0;
    end else if (flush) begin
      r_cdb_en <= 1'b0;
    end else if (w_grant) begin
      r_cdb_en     <= 1'b1;
      r_cdb_vregid <= w_head[w_grant_idx].vregid;
      r_cdb_val    <= w_head[w_grant_idx].val;
      r_cdb_src    <= w_grant_idx;
      r_rr_ptr     <= (w_grant_idx == SW'(NUM_SRC - 1)) ? '0 : w_grant_idx + 1'b1;
    end else begin
      r_cdb_en <= 1'b0;
    end
  end

  assign src_ready  = ~w_full;
  assign cdb_en     = r_cdb_en;
  assign cdb_vregid = r_cdb_vregid;
  assign cdb_val    = r_cdb_val;
  assign cdb_src    = r_cdb_src;
endmodule
